// File: rtl/inert_seq.sv
// rtl/inert_seq.sv - inertial sensor sequencer: power-up wait, config writes, sample reads
module inert_seq #(
  parameter int INIT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG_ISSUE,
    CFG_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    PUBLISH
  } state_t;

  localparam logic [15:0] INIT_LIM = 16'(INIT_CYCLES);

  state_t      state;
  logic [15:0] pwr_cnt;
  logic [1:0]  idx;
  logic [7:0]  byte_r [4];
  logic        int_meta;
  logic        int_sync;
  logic        done_ok;

  // Only the low byte of each SPI read carries sensor data.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];

  // A done arriving in the same cycle as our own wrt cannot belong to that
  // transaction, so it is never consumed.
  assign done_ok = done && !wrt;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    case (i)
      2'd0:    cfg_cmd = 16'h0D02;  // INT on data-ready
      2'd1:    cfg_cmd = 16'h1053;  // accel 208Hz +/-2g
      2'd2:    cfg_cmd = 16'h1150;  // gyro 208Hz 245dps
      default: cfg_cmd = 16'h1460;  // rounding
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    case (i)
      2'd0:    rd_cmd = 16'hA200;  // pitch low
      2'd1:    rd_cmd = 16'hA300;  // pitch high
      2'd2:    rd_cmd = 16'hAC00;  // AZ low
      default: rd_cmd = 16'hAD00;  // AZ high
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous data-ready line.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_meta <= INT;
      int_sync <= int_meta;
    end
  end

  // Sequencer FSM with registered wrt/cmd/vld and sample outputs.
  // The sample pair is loaded on the edge that enters PUBLISH, so vld and the
  // new ptch_rt/AZ are visible together during PUBLISH, one cycle after the
  // last read done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PWR_WAIT;
      pwr_cnt <= 16'd0;
      idx     <= 2'd0;
      wrt     <= 1'b0;
      vld     <= 1'b0;
      cmd     <= 16'h0000;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
      for (int i = 0; i < 4; i++) byte_r[i] <= 8'h00;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == INIT_LIM) begin
            pwr_cnt <= 16'd0;
            state   <= CFG_ISSUE;
          end else begin
            pwr_cnt <= pwr_cnt + 16'd1;
          end
        end
        CFG_ISSUE: begin
          wrt   <= 1'b1;
          cmd   <= cfg_cmd(idx);
          state <= CFG_WAIT;
        end
        CFG_WAIT: begin
          if (done_ok) begin
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              state <= IDLE;
            end else begin
              idx   <= idx + 2'd1;
              state <= CFG_ISSUE;
            end
          end
        end
        IDLE: begin
          if (int_sync) begin
            idx   <= 2'd0;
            state <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          wrt   <= 1'b1;
          cmd   <= rd_cmd(idx);
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (done_ok) begin
            byte_r[idx] <= rd_data[7:0];
            if (idx == 2'd3) begin
              ptch_rt <= {byte_r[1], byte_r[0]};
              AZ      <= {rd_data[7:0], byte_r[2]};
              vld     <= 1'b1;
              idx     <= 2'd0;
              state   <= PUBLISH;
            end else begin
              idx   <= idx + 2'd1;
              state <= RD_ISSUE;
            end
          end
        end
        PUBLISH: begin
          state <= IDLE;
        end
        default: begin
          state <= PWR_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inert_seq.sv
// tb/tb_inert_seq.sv - randomized bench for inert_seq with command-stream reference model
module tb_inert_seq;

  localparam int INIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;

  always #5 clk = ~clk;

  inert_seq #(.INIT_CYCLES(INIT)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .vld     (vld),
    .ptch_rt (ptch_rt),
    .AZ      (AZ)
  );

  logic [15:0] cfg_tbl [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] rd_tbl  [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
  logic [7:0]  fix_tbl [4] = '{8'h34, 8'h12, 8'h78, 8'h56};

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          cyc = 0;
  int          pos = 0;          // transactions seen since reset
  int          rel_cyc = 0;
  bit          first_wrt = 1'b1;
  bit          busy = 1'b0;
  int          lat_cnt = 0;
  int          cur_pos = 0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [7:0]  bts [4];
  logic [31:0] samp_q [$];
  int          vld_q [$];
  logic [15:0] held_p = 16'h0000;
  logic [15:0] held_a = 16'h0000;
  int          vld_cnt = 0;
  int          grp_cnt = 0;
  int          cfg_done_cyc = 0;
  int          last_vld_cyc = 0;
  int          last_wrt_cyc = 0;
  int          wrt_cnt = 0;
  int          spur_pub_cyc = -1;
  bit          have_vld = 1'b0;
  bit          fixed_bytes = 1'b0;
  bit          chk_first_rd = 1'b0;
  bit          int_cont = 1'b0;
  bit          arm_spur_pub = 1'b0;
  bit          rd1_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_cmd(input int p);
    if (p < 4) return cfg_tbl[p];
    return rd_tbl[(p - 4) % 4];
  endfunction

  // One clock cycle: observe outputs, play the SPI master, track commands.
  task automatic tick();
    logic [31:0] s;
    logic [7:0]  b;
    int          ri;
    bit          busy_before;
    @(posedge clk);
    #1;
    cyc++;
    busy_before = busy;

    if (vld) begin
      vld_cnt++;
      if (vld_q.size() > 0) begin
        check_eq("vld_lat", cyc, vld_q.pop_front());
        s = samp_q.pop_front();
        check_eq("ptch_rt", ptch_rt, s[31:16]);
        check_eq("AZ", AZ, s[15:0]);
        held_p = s[31:16];
        held_a = s[15:0];
        have_vld = 1'b1;
        last_vld_cyc = cyc;
      end else begin
        check_eq("vld_spurious", vld, 0);
      end
    end else begin
      check_eq("ptch_hold", ptch_rt, held_p);
      check_eq("az_hold", AZ, held_a);
      if (vld_q.size() > 0 && vld_q[0] <= cyc) begin
        check_eq("vld_missing", vld, 1);
        void'(vld_q.pop_front());
        void'(samp_q.pop_front());
      end
    end

    if (busy_before) check_eq("cmd_hold", cmd, cur_cmd);

    done = 1'b0;
    if (busy) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        busy = 1'b0;
        done = 1'b1;
        b = 8'($urandom);
        if (cur_pos < 4) begin
          if (cur_pos == 3) cfg_done_cyc = cyc;
        end else begin
          ri = (cur_pos - 4) % 4;
          if (fixed_bytes) b = fix_tbl[ri];
          bts[ri] = b;
          if (ri == 1) rd1_done = 1'b1;
          if (ri == 3) begin
            grp_cnt++;
            samp_q.push_back({bts[1], bts[0], bts[3], bts[2]});
            vld_q.push_back(cyc + 1);
            if (arm_spur_pub) spur_pub_cyc = cyc + 1;
          end
        end
        rd_data = {8'($urandom), b};
      end
    end else if (spur_pub_cyc == cyc) begin
      done = 1'b1;
      rd_data = 16'hA5C3;
    end

    if (wrt) begin
      wrt_cnt++;
      last_wrt_cyc = cyc;
      check_eq("wrt_overlap", busy_before, 0);
      check_eq("cmd", cmd, exp_cmd(pos));
      if (first_wrt) check_eq("first_wrt_lat", cyc - rel_cyc, INIT + 2);
      first_wrt = 1'b0;
      if (pos == 4 && chk_first_rd) check_eq("first_rd_lat", cyc - cfg_done_cyc, 3);
      if (pos >= 4 && (pos - 4) % 4 == 0 && int_cont && have_vld)
        check_eq("b2b_lat", cyc - last_vld_cyc, 3);
      busy = 1'b1;
      lat_cnt = $urandom_range(1, 4);
      cur_pos = pos;
      cur_cmd = exp_cmd(pos);
      pos++;
    end
  endtask

  task automatic do_reset(input bit int_level);
    rst = 1'b1;
    done = 1'b0;
    INT = int_level;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("rst_wrt", wrt, 0);
    check_eq("rst_vld", vld, 0);
    check_eq("rst_cmd", cmd, 16'h0000);
    check_eq("rst_ptch", ptch_rt, 16'h0000);
    check_eq("rst_az", AZ, 16'h0000);
    busy = 1'b0;
    pos = 0;
    samp_q.delete();
    vld_q.delete();
    held_p = 16'h0000;
    held_a = 16'h0000;
    first_wrt = 1'b1;
    have_vld = 1'b0;
    rd1_done = 1'b0;
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic pulse_int(input int w);
    INT = 1'b1;
    repeat (w) tick();
    INT = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 400; i++) begin
      if (!busy && vld_q.size() == 0 && (cyc - last_wrt_cyc) > 8) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("drain_timeout", ok, 1);
  endtask

  initial begin
    int mark;
    int target;

    do_reset(1'b0);
    for (int i = 0; i < 300 && !(pos == 4 && !busy); i++) tick();
    check_eq("cfg_done", pos, 4);
    repeat (5) tick();

    // directed sample
    fixed_bytes = 1'b1;
    pulse_int(2);
    drain();
    check_eq("dir_ptch", ptch_rt, 16'h1234);
    check_eq("dir_az", AZ, 16'h5678);
    fixed_bytes = 1'b0;

    // spurious done while idle
    mark = wrt_cnt;
    done = 1'b1;
    rd_data = 16'h00EE;
    repeat (10) tick();
    check_eq("idle_spur_wrt", wrt_cnt - mark, 0);

    // spurious done during PUBLISH, then a normal sample
    arm_spur_pub = 1'b1;
    pulse_int(1);
    drain();
    arm_spur_pub = 1'b0;
    pulse_int(1);
    drain();

    // randomized interrupts and gaps
    for (int k = 0; k < 15; k++) begin
      pulse_int($urandom_range(1, 3));
      repeat ($urandom_range(0, 40)) tick();
    end
    drain();

    // INT held high: back-to-back samples
    int_cont = 1'b1;
    have_vld = 1'b0;
    target = vld_cnt + 5;
    INT = 1'b1;
    for (int i = 0; i < 1000 && vld_cnt < target; i++) tick();
    check_eq("b2b_count", vld_cnt >= target, 1);
    int_cont = 1'b0;
    INT = 1'b0;
    drain();

    // reset between 2nd and 3rd read done, INT high through config
    rd1_done = 1'b0;
    pulse_int(1);
    for (int i = 0; i < 200 && !rd1_done; i++) tick();
    check_eq("rd1_seen", rd1_done, 1);
    tick();
    chk_first_rd = 1'b1;
    do_reset(1'b1);
    for (int i = 0; i < 300 && pos < 5; i++) tick();
    check_eq("post_rst_rd", pos >= 5, 1);
    chk_first_rd = 1'b0;
    INT = 1'b0;
    drain();

    check_eq("vld_count", vld_cnt, grp_cnt);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
